// File: rtl/hex_dump_fmt_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : hex_dump_fmt_pkg
// Description : Shared types, ASCII constants and nibble-to-ASCII helper for
//               the hex dump formatter (HEXDUMP_ADDR_EN adds the ADDR state).
// Revision    : 1.0 - initial release
// ============================================================================
package hex_dump_fmt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
`ifdef HEXDUMP_ADDR_EN
        ST_ADDR = 3'd1,
`endif
        ST_HI   = 3'd2,
        ST_LO   = 3'd3,
        ST_SEP  = 3'd4,
        ST_CR   = 3'd5,
        ST_LF   = 3'd6
    } state_t;

    typedef enum logic {
        PH_EMIT = 1'b0,
        PH_WAIT = 1'b1
    } phase_t;

    localparam logic [7:0] c_ASCII_SP    = 8'h20;
    localparam logic [7:0] c_ASCII_CR    = 8'h0D;
    localparam logic [7:0] c_ASCII_LF    = 8'h0A;
    localparam logic [7:0] c_ASCII_COLON = 8'h3A;

    // Strobe cycle plus the two cycles where the UART's ready output lags.
    localparam logic [1:0] c_WAIT_LOAD   = 2'd3;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10)
            return 8'h30 + {4'h0, nib};
        else
            return 8'h37 + {4'h0, nib};
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex_dump_fmt_byte_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : byte_fifo
// Description : Byte FIFO with combinational read data and a drop indication
//               for pushes that cannot be accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty,
    output logic       drop
);

    localparam int                c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]  c_FULL  = (c_PTR_W+1)'(DEPTH);

    logic [7:0]          r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W:0]    r_count;

    logic w_pop;
    logic w_wr;

    assign full     = (r_count == c_FULL);
    assign empty    = (r_count == '0);
    assign w_pop    = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_wr     = push && (!full || w_pop);
    assign drop     = push && !w_wr;
    assign pop_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/hex_dump_fmt.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : hex_dump_fmt
// Description : Renders a flash byte stream as ASCII hex lines for a UART.
//               Define HEXDUMP_ADDR_EN to prefix each line with its address.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_dump_fmt
    import hex_dump_fmt_pkg::*;
#(
    parameter int          DEPTH          = 16,
    parameter int          BYTES_PER_LINE = 16,
    parameter logic [23:0] BASE_ADDR      = 24'h100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       tx_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       fifo_full,
    output logic       overflow,
    output logic       busy
);

    localparam logic [7:0] c_LINE_LAST = 8'(BYTES_PER_LINE);

    logic       w_fifo_pop;
    logic [7:0] w_fifo_data;
    logic       w_fifo_empty;
    logic       w_fifo_drop;
    logic [7:0] w_char;

    state_t      r_state;
    phase_t      r_phase;
    logic [1:0]  r_wait_cnt;
    logic [7:0]  r_byte;
    logic [7:0]  r_line_cnt;
    logic [23:0] r_addr;
    logic        r_tx_start;
    logic [7:0]  r_tx_data;
    logic        r_overflow;
`ifdef HEXDUMP_ADDR_EN
    logic [2:0]  r_nib_cnt;
`endif

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (w_fifo_pop),
        .pop_data  (w_fifo_data),
        .full      (fifo_full),
        .empty     (w_fifo_empty),
        .drop      (w_fifo_drop)
    );

    assign w_fifo_pop = (r_state == ST_IDLE) && !w_fifo_empty;
    assign tx_start   = r_tx_start;
    assign tx_data    = r_tx_data;
    assign overflow   = r_overflow;
    assign busy       = !w_fifo_empty || (r_state != ST_IDLE);

    always_comb begin
        w_char = c_ASCII_SP;
        case (r_state)
`ifdef HEXDUMP_ADDR_EN
            ST_ADDR: begin
                case (r_nib_cnt)
                    3'd0:    w_char = nibble_to_ascii(r_addr[23:20]);
                    3'd1:    w_char = nibble_to_ascii(r_addr[19:16]);
                    3'd2:    w_char = nibble_to_ascii(r_addr[15:12]);
                    3'd3:    w_char = nibble_to_ascii(r_addr[11:8]);
                    3'd4:    w_char = nibble_to_ascii(r_addr[7:4]);
                    3'd5:    w_char = nibble_to_ascii(r_addr[3:0]);
                    3'd6:    w_char = c_ASCII_COLON;
                    default: w_char = c_ASCII_SP;
                endcase
            end
`endif
            ST_HI:   w_char = nibble_to_ascii(r_byte[7:4]);
            ST_LO:   w_char = nibble_to_ascii(r_byte[3:0]);
            ST_SEP:  w_char = c_ASCII_SP;
            ST_CR:   w_char = c_ASCII_CR;
            ST_LF:   w_char = c_ASCII_LF;
            default: w_char = c_ASCII_SP;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_phase    <= PH_EMIT;
            r_wait_cnt <= '0;
            r_byte     <= '0;
            r_line_cnt <= '0;
            r_addr     <= BASE_ADDR;
            r_tx_start <= 1'b0;
            r_tx_data  <= c_ASCII_SP;
            r_overflow <= 1'b0;
`ifdef HEXDUMP_ADDR_EN
            r_nib_cnt  <= '0;
`endif
        end else begin
            r_tx_start <= 1'b0;
            if (w_fifo_drop)
                r_overflow <= 1'b1;

            if (r_state == ST_IDLE) begin
                if (!w_fifo_empty) begin
                    r_byte  <= w_fifo_data;
                    r_phase <= PH_EMIT;
`ifdef HEXDUMP_ADDR_EN
                    r_nib_cnt <= '0;
                    r_state   <= (r_line_cnt == 8'd0) ? ST_ADDR : ST_HI;
`else
                    r_state   <= ST_HI;
`endif
                end
            end else if (r_phase == PH_EMIT) begin
                // The !r_tx_start term keeps strobes at least two cycles apart.
                if (tx_ready && !r_tx_start) begin
                    r_tx_start <= 1'b1;
                    r_tx_data  <= w_char;
                    r_phase    <= PH_WAIT;
                    r_wait_cnt <= c_WAIT_LOAD;
                end
            end else if (r_wait_cnt != 2'd0) begin
                r_wait_cnt <= r_wait_cnt - 2'd1;
            end else if (tx_ready) begin
                r_phase <= PH_EMIT;
                case (r_state)
`ifdef HEXDUMP_ADDR_EN
                    ST_ADDR: begin
                        if (r_nib_cnt == 3'd7)
                            r_state <= ST_HI;
                        else
                            r_nib_cnt <= r_nib_cnt + 3'd1;
                    end
`endif
                    ST_HI:   r_state <= ST_LO;
                    ST_LO: begin
                        r_addr <= r_addr + 24'd1;
                        if (r_line_cnt + 8'd1 == c_LINE_LAST) begin
                            r_line_cnt <= '0;
                            r_state    <= ST_CR;
                        end else begin
                            r_line_cnt <= r_line_cnt + 8'd1;
                            r_state    <= ST_SEP;
                        end
                    end
                    ST_CR:   r_state <= ST_LF;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hex_dump_fmt.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_hex_dump_fmt
// Description : Scoreboard bench for hex_dump_fmt with a simple UART model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_dump_fmt;

    localparam int          c_BPL  = 16;
    localparam logic [23:0] c_BASE = 24'h100000;
`ifdef HEXDUMP_ADDR_EN
    localparam int c_PFX = 8;
`else
    localparam int c_PFX = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       tx_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       fifo_full;
    logic       overflow;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int strobe_cnt = 0;
    int frame_len = 4;
    int uart_cnt = 0;
    logic hold = 1'b0;

    logic [7:0]  exp_q[$];
    int          tb_line = 0;
    logic [23:0] tb_addr = c_BASE;
    string       hex_s = "0123456789ABCDEF";

    hex_dump_fmt #(
        .DEPTH          (16),
        .BYTES_PER_LINE (c_BPL),
        .BASE_ADDR      (c_BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .tx_ready  (tx_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .fifo_full (fifo_full),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // UART model: busy for frame_len cycles after each strobe.
    always @(posedge clk) begin
        if (!rst)
            uart_cnt <= 0;
        else if (tx_start)
            uart_cnt <= frame_len;
        else if (uart_cnt > 0)
            uart_cnt <= uart_cnt - 1;
    end
    assign tx_ready = (uart_cnt == 0) && !hold;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst && tx_start) begin
            strobe_cnt++;
            if (exp_q.size() == 0)
                chk("tx_unexpected", {24'h0, tx_data}, 32'hFFFF_FFFF);
            else
                chk("tx_char", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
        end
    end

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++)
            exp_q.push_back(s[i]);
    endtask

    task automatic exp_byte(input logic [7:0] b);
`ifdef HEXDUMP_ADDR_EN
        if (tb_line == 0) begin
            for (int k = 5; k >= 0; k--)
                exp_q.push_back(hex_s[int'((tb_addr >> (4*k)) & 24'hF)]);
            push_str(": ");
        end
`endif
        exp_q.push_back(hex_s[int'(b[7:4])]);
        exp_q.push_back(hex_s[int'(b[3:0])]);
        tb_addr = tb_addr + 24'd1;
        if (tb_line + 1 == c_BPL) begin
            tb_line = 0;
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end else begin
            tb_line++;
            exp_q.push_back(8'h20);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        hold = 1'b0;
        exp_q.delete();
        tb_line = 0;
        tb_addr = c_BASE;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        strobe_cnt = 0;
    endtask

    // Back-to-back bytes first+i; only the first n_keep produce output.
    task automatic send_seq(input logic [7:0] first, input int n, input int n_keep);
        for (int i = 0; i < n; i++) begin
            if (i < n_keep)
                exp_byte(first + 8'(i));
            @(negedge clk);
            in_data  = first + 8'(i);
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_busy", {31'h0, busy}, 32'h0);
        chk("drain_pending", exp_q.size(), 32'h0);
    endtask

    task automatic wait_strobes(input int target);
        int n = 0;
        while (strobe_cnt < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_strobes", strobe_cnt, target);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_tx_start", {31'h0, tx_start}, 32'h0);
        chk("rst_tx_data", {24'h0, tx_data}, 32'h20);
        chk("rst_fifo_full", {31'h0, fifo_full}, 32'h0);
        chk("rst_overflow", {31'h0, overflow}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);

        // Single byte A5 through a fast UART.
        do_reset();
        frame_len = 1;
`ifdef HEXDUMP_ADDR_EN
        push_str("100000: ");
`endif
        push_str("A5 ");
        @(negedge clk);
        in_data = 8'hA5;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        drain();
        chk("t1_overflow", {31'h0, overflow}, 32'h0);

        // Full line 00..0F ends with CR LF, no trailing space.
        do_reset();
        frame_len = 4;
        send_seq(8'h00, 16, 16);
        drain();

        // Ready held low after the first strobe.
        do_reset();
        frame_len = 4;
        send_seq(8'h5A, 2, 2);
        wait_strobes(1);
        hold = 1'b1;
        repeat (100) @(negedge clk);
        chk("hold_strobes", strobe_cnt, 32'd1);
`ifdef HEXDUMP_ADDR_EN
        chk("hold_tx_data", {24'h0, tx_data}, 32'h31);
`else
        chk("hold_tx_data", {24'h0, tx_data}, 32'h35);
`endif
        hold = 1'b0;
        drain();

        // 18-byte burst into a slow UART: one byte dropped.
        do_reset();
        frame_len = 40;
        send_seq(8'h80, 18, 17);
        chk("burst_overflow", {31'h0, overflow}, 32'h1);
        chk("burst_full", {31'h0, fifo_full}, 32'h1);
        drain();
        chk("burst_overflow_sticky", {31'h0, overflow}, 32'h1);
        chk("burst_not_full", {31'h0, fifo_full}, 32'h0);

        // Reset during the LO wait phase.
        do_reset();
        frame_len = 4;
        send_seq(8'h77, 1, 1);
        wait_strobes(c_PFX + 2);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_tx_start", {31'h0, tx_start}, 32'h0);
        chk("mid_rst_tx_data", {24'h0, tx_data}, 32'h20);
        chk("mid_rst_busy", {31'h0, busy}, 32'h0);
        chk("mid_rst_full", {31'h0, fifo_full}, 32'h0);
        chk("mid_rst_overflow", {31'h0, overflow}, 32'h0);
        do_reset();
`ifdef HEXDUMP_ADDR_EN
        push_str("100000: ");
`endif
        push_str("3C ");
        @(negedge clk);
        in_data = 8'h3C;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
